// File: rtl/complex_mult_pkg.sv
// Shared helpers for the complex multiplier stream: result width, rounding
// constant and parameter legality predicates.
package complex_mult_pkg;

  localparam int MIN_DOUT_WIDTH = 2;

  function automatic int full_width(input int din);
    return 2 * din + 1;
  endfunction

  function automatic longint round_const(input int shift);
    return (shift == 0) ? 64'sd0 : (64'sd1 <<< (shift - 1));
  endfunction

  function automatic bit shift_legal(input int din, input int shift);
    return (shift >= 0) && (shift <= 2 * din);
  endfunction

  function automatic bit dout_legal(input int dout);
    return dout >= MIN_DOUT_WIDTH;
  endfunction

endpackage

// File: rtl/complex_mult_stream_rnd_sat.sv
// Combinational round-half-up, arithmetic right shift and symmetric clamp
// of one full-precision component into the output width.
module rnd_sat
  import complex_mult_pkg::*;
#(
  parameter int IN_W  = 33,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15
) (
  input  logic signed [IN_W-1:0]  x,
  output logic signed [OUT_W-1:0] y,
  output logic                    sat
);

  localparam int EW = IN_W + 1;
  localparam logic signed [EW-1:0] RC = EW'(round_const(SHIFT));

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] shifted;

  // One guard bit keeps the rounding add from wrapping.
  assign ext     = {x[IN_W-1], x};
  assign shifted = (ext + RC) >>> SHIFT;

  if (OUT_W >= EW - SHIFT) begin : g_wide
    assign y   = OUT_W'(shifted);
    assign sat = 1'b0;
  end else begin : g_clamp
    localparam int TW = EW - OUT_W + 1;
    logic [TW-1:0] top;
    logic          over;

    // Value fits iff every bit from the output sign bit upward agrees.
    assign top  = shifted[EW-1:OUT_W-1];
    assign over = !((&top) || !(|top));
    assign sat  = over;

    always_comb begin
      y = shifted[OUT_W-1:0];
      if (over) begin
        y = shifted[EW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/complex_mult_stream.sv
// Five-stage global-enable pipelined complex multiplier (three-multiplier form)
// with per-beat conjugate, round/saturate output scaling and sticky overflow.
module complex_mult_stream
  import complex_mult_pkg::*;
#(
  parameter int C_DIN_WIDTH  = 16,
  parameter int C_DOUT_WIDTH = 16,
  parameter int C_SHIFT      = 15,
  parameter int C_TAG_WIDTH  = 4
) (
  input  logic                           I_clk,
  input  logic                           I_rst_n,
  input  logic signed [C_DIN_WIDTH-1:0]  I_data1_i,
  input  logic signed [C_DIN_WIDTH-1:0]  I_data1_q,
  input  logic signed [C_DIN_WIDTH-1:0]  I_data2_i,
  input  logic signed [C_DIN_WIDTH-1:0]  I_data2_q,
  input  logic                           I_conj,
  input  logic        [C_TAG_WIDTH-1:0]  I_tag,
  input  logic                           I_data_v,
  output logic                           O_ready,
  output logic signed [C_DOUT_WIDTH-1:0] O_data_i,
  output logic signed [C_DOUT_WIDTH-1:0] O_data_q,
  output logic        [C_TAG_WIDTH-1:0]  O_tag,
  output logic                           O_data_v,
  input  logic                           I_ready,
  output logic                           O_sat,
  output logic                           O_ovf,
  input  logic                           I_ovf_clr
);

  localparam int DW = C_DIN_WIDTH;
  localparam int CW = DW + 1;
  localparam int AW = DW + 2;
  localparam int FW = full_width(DW);
  localparam int PW = AW + CW;

  if (!shift_legal(C_DIN_WIDTH, C_SHIFT)) begin : g_bad_shift
    $error("complex_mult_stream: C_SHIFT must lie in 0..2*C_DIN_WIDTH");
  end
  if (!dout_legal(C_DOUT_WIDTH)) begin : g_bad_dout
    $error("complex_mult_stream: C_DOUT_WIDTH must be at least 2");
  end

  logic en;
  assign en      = !O_data_v || I_ready;
  assign O_ready = en;

  logic s1_v, s2_v, s3_v, s4_v;

  logic signed [DW-1:0]       s1_i1, s1_q1, s1_i2, s1_q2;
  logic                       s1_conj;
  logic [C_TAG_WIDTH-1:0]     s1_tag, s2_tag, s3_tag, s4_tag;

  logic signed [DW-1:0]       s2_i1, s2_q1;
  logic signed [CW-1:0]       s2_q2;
  logic signed [AW-1:0]       s2_s0, s2_s1, s2_s2;

  logic signed [PW-1:0]       s3_m0, s3_m1, s3_m2;
  logic signed [FW-1:0]       s4_re, s4_im;

  logic signed [CW-1:0]       q2_ext, q2_c;
  logic signed [C_DOUT_WIDTH-1:0] rs_i, rs_q;
  logic                       sat_i, sat_q;

  // Extra bit so conjugating the most negative input is exact.
  assign q2_ext = CW'(s1_q2);
  assign q2_c   = s1_conj ? -q2_ext : q2_ext;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s3_v <= 1'b0;
      s4_v <= 1'b0;
    end else if (en) begin
      s1_v <= I_data_v;
      s2_v <= s1_v;
      s3_v <= s2_v;
      s4_v <= s3_v;
    end
  end

  // Datapath stages carry no reset so the multiplies map cleanly onto DSPs.
  always_ff @(posedge I_clk) begin
    if (en) begin
      s1_i1   <= I_data1_i;
      s1_q1   <= I_data1_q;
      s1_i2   <= I_data2_i;
      s1_q2   <= I_data2_q;
      s1_conj <= I_conj;
      s1_tag  <= I_tag;

      s2_i1  <= s1_i1;
      s2_q1  <= s1_q1;
      s2_q2  <= q2_c;
      s2_s0  <= AW'(s1_i1) - AW'(s1_q1);
      s2_s1  <= AW'(s1_i2) - AW'(q2_c);
      s2_s2  <= AW'(s1_i2) + AW'(q2_c);
      s2_tag <= s1_tag;

      s3_m0  <= PW'(s2_s0) * PW'(s2_q2);
      s3_m1  <= PW'(s2_s1) * PW'(s2_i1);
      s3_m2  <= PW'(s2_s2) * PW'(s2_q1);
      s3_tag <= s2_tag;

      // True results always fit FW bits, so modular truncation is exact.
      s4_re  <= FW'(s3_m1 + s3_m0);
      s4_im  <= FW'(s3_m2 + s3_m0);
      s4_tag <= s3_tag;
    end
  end

  rnd_sat #(
    .IN_W  (FW),
    .OUT_W (C_DOUT_WIDTH),
    .SHIFT (C_SHIFT)
  ) u_rnd_sat_i (
    .x   (s4_re),
    .y   (rs_i),
    .sat (sat_i)
  );

  rnd_sat #(
    .IN_W  (FW),
    .OUT_W (C_DOUT_WIDTH),
    .SHIFT (C_SHIFT)
  ) u_rnd_sat_q (
    .x   (s4_im),
    .y   (rs_q),
    .sat (sat_q)
  );

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_data_v <= 1'b0;
      O_data_i <= '0;
      O_data_q <= '0;
      O_tag    <= '0;
      O_sat    <= 1'b0;
    end else if (en) begin
      O_data_v <= s4_v;
      O_data_i <= rs_i;
      O_data_q <= rs_q;
      O_tag    <= s4_tag;
      O_sat    <= sat_i | sat_q;
    end
  end

  // A saturating transfer outranks a simultaneous clear.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_ovf <= 1'b0;
    end else if (O_data_v && I_ready && O_sat) begin
      O_ovf <= 1'b1;
    end else if (I_ovf_clr) begin
      O_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_complex_mult_stream.sv
// Bench for complex_mult_stream: three parameterisations share one input
// stream; outputs are compared with a plain complex-arithmetic reference.
module tb_complex_mult_stream;

  localparam int DW = 16;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic signed [DW-1:0] d1i, d1q, d2i, d2q;
  logic conj, din_v, dout_rdy, ovf_clr;
  logic [TW-1:0] tag;

  logic rdy0, rdy1, rdy2;
  logic signed [15:0] oi0, oq0, oi2, oq2;
  logic signed [32:0] oi1, oq1;
  logic [TW-1:0] ot0, ot1, ot2;
  logic ov0, ov1, ov2, sat0, sat1, sat2, ovf0, ovf1, ovf2;

  int checks = 0;
  int errors = 0;
  int n_out = 0;

  always #5 clk = ~clk;

  complex_mult_stream u_dut0 (
    .I_clk(clk), .I_rst_n(rst_n),
    .I_data1_i(d1i), .I_data1_q(d1q), .I_data2_i(d2i), .I_data2_q(d2q),
    .I_conj(conj), .I_tag(tag), .I_data_v(din_v), .O_ready(rdy0),
    .O_data_i(oi0), .O_data_q(oq0), .O_tag(ot0), .O_data_v(ov0),
    .I_ready(dout_rdy), .O_sat(sat0), .O_ovf(ovf0), .I_ovf_clr(ovf_clr)
  );

  complex_mult_stream #(.C_DIN_WIDTH(16), .C_DOUT_WIDTH(33), .C_SHIFT(0), .C_TAG_WIDTH(4)) u_dut1 (
    .I_clk(clk), .I_rst_n(rst_n),
    .I_data1_i(d1i), .I_data1_q(d1q), .I_data2_i(d2i), .I_data2_q(d2q),
    .I_conj(conj), .I_tag(tag), .I_data_v(din_v), .O_ready(rdy1),
    .O_data_i(oi1), .O_data_q(oq1), .O_tag(ot1), .O_data_v(ov1),
    .I_ready(dout_rdy), .O_sat(sat1), .O_ovf(ovf1), .I_ovf_clr(ovf_clr)
  );

  complex_mult_stream #(.C_DIN_WIDTH(16), .C_DOUT_WIDTH(16), .C_SHIFT(1), .C_TAG_WIDTH(4)) u_dut2 (
    .I_clk(clk), .I_rst_n(rst_n),
    .I_data1_i(d1i), .I_data1_q(d1q), .I_data2_i(d2i), .I_data2_q(d2q),
    .I_conj(conj), .I_tag(tag), .I_data_v(din_v), .O_ready(rdy2),
    .O_data_i(oi2), .O_data_q(oq2), .O_tag(ot2), .O_data_v(ov2),
    .I_ready(dout_rdy), .O_sat(sat2), .O_ovf(ovf2), .I_ovf_clr(ovf_clr)
  );

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic longint scale(input longint x, input int shift, input int dw, output bit s);
    longint r, hi, lo;
    r  = (shift == 0) ? x : ((x + (longint'(1) <<< (shift - 1))) >>> shift);
    hi = (longint'(1) <<< (dw - 1)) - 1;
    lo = -(longint'(1) <<< (dw - 1));
    s  = 1'b0;
    if (r > hi) begin r = hi; s = 1'b1; end
    else if (r < lo) begin r = lo; s = 1'b1; end
    return r;
  endfunction

  function automatic void model(input longint i1, q1, i2, q2, input bit cj, input int shift,
                                input int dw, output longint ri, output longint rq, output bit sat);
    longint qc, re, im;
    bit si, sq;
    qc  = cj ? -q2 : q2;
    re  = i1 * i2 - q1 * qc;
    im  = i1 * qc + q1 * i2;
    ri  = scale(re, shift, dw, si);
    rq  = scale(im, shift, dw, sq);
    sat = si | sq;
  endfunction

  typedef struct {
    longint i1, q1, i2, q2;
    bit cj;
    logic [TW-1:0] tag;
  } beat_t;

  beat_t sb[$];

  bit held = 1'b0;
  longint h_i, h_q, h_tag, h_sat;

  always @(negedge clk) begin
    beat_t b;
    longint ei, eq;
    bit es;
    if (!rst_n) begin
      sb.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", ov0, 1);
        chk("hold_i", oi0, h_i);
        chk("hold_q", oq0, h_q);
        chk("hold_tag", ot0, h_tag);
        chk("hold_sat", sat0, h_sat);
      end
      held = ov0 && !dout_rdy;
      h_i = oi0; h_q = oq0; h_tag = ot0; h_sat = sat0;
      if (ov0 && dout_rdy) begin
        n_out++;
        chk("beat_expected", longint'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          b = sb.pop_front();
          model(b.i1, b.q1, b.i2, b.q2, b.cj, 15, 16, ei, eq, es);
          chk("d0_i", oi0, ei); chk("d0_q", oq0, eq); chk("d0_sat", sat0, es); chk("d0_tag", ot0, b.tag);
          model(b.i1, b.q1, b.i2, b.q2, b.cj, 0, 33, ei, eq, es);
          chk("d1_i", oi1, ei); chk("d1_q", oq1, eq); chk("d1_sat", sat1, es); chk("d1_tag", ot1, b.tag);
          model(b.i1, b.q1, b.i2, b.q2, b.cj, 1, 16, ei, eq, es);
          chk("d2_i", oi2, ei); chk("d2_q", oq2, eq); chk("d2_sat", sat2, es); chk("d2_tag", ot2, b.tag);
        end
      end
      if (din_v && rdy0) sb.push_back('{longint'(d1i), longint'(d1q), longint'(d2i), longint'(d2q), conj, tag});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input longint i1, q1, i2, q2, input bit cj, input logic [TW-1:0] t);
    d1i = 16'(i1); d1q = 16'(q1); d2i = 16'(i2); d2q = 16'(q2);
    conj = cj; tag = t; din_v = 1'b1;
    tick();
    din_v = 1'b0;
  endtask

  function automatic longint rnd16();
    case ($urandom_range(0, 7))
      0: return -32768;
      1: return 32767;
      default: return longint'($signed(16'($urandom)));
    endcase
  endfunction

  function automatic longint out_i(input int inst);
    case (inst) 0: return oi0; 1: return oi1; default: return oi2; endcase
  endfunction
  function automatic longint out_q(input int inst);
    case (inst) 0: return oq0; 1: return oq1; default: return oq2; endcase
  endfunction
  function automatic longint out_sat(input int inst);
    case (inst) 0: return sat0; 1: return sat1; default: return sat2; endcase
  endfunction

  typedef struct {
    int inst;
    longint i1, q1, i2, q2;
    bit cj;
    longint ei, eq;
    bit es;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

  initial begin
    int lat, n, cyc, n0;
    bit acc;

    vecs[0] = '{1, 1, 2, 3, 4, 1'b0, -5, 10, 1'b0};
    vecs[1] = '{1, 1, 2, 3, 4, 1'b1, 11, 2, 1'b0};
    vecs[2] = '{0, -32768, -32768, -32768, -32768, 1'b0, 0, 32767, 1'b1};
    vecs[3] = '{0, -32768, -32768, -32768, -32768, 1'b1, 32767, 0, 1'b1};
    vecs[4] = '{2, 3, 0, 1, 0, 1'b0, 2, 0, 1'b0};
    vecs[5] = '{2, -3, 0, 1, 0, 1'b0, -1, 0, 1'b0};

    rst_n = 1'b1; din_v = 1'b0; dout_rdy = 1'b1; ovf_clr = 1'b0; conj = 1'b0;
    d1i = '0; d1q = '0; d2i = '0; d2q = '0; tag = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", ov0, 0); chk("rst_ready", rdy0, 1); chk("rst_ovf", ovf0, 0);
    chk("rst_i", oi0, 0); chk("rst_q", oq0, 0); chk("rst_tag", ot0, 0); chk("rst_sat", sat0, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    for (int k = 0; k < 6; k++) begin
      send_one(vecs[k].i1, vecs[k].q1, vecs[k].i2, vecs[k].q2, vecs[k].cj, 4'(k));
      lat = 1;
      while (!ov0 && lat < 20) begin tick(); lat++; end
      chk("vec_latency", lat, 5);
      chk("vec_i", out_i(vecs[k].inst), vecs[k].ei);
      chk("vec_q", out_q(vecs[k].inst), vecs[k].eq);
      chk("vec_sat", out_sat(vecs[k].inst), vecs[k].es);
      tick();
      if (k == 2) chk("ovf_set", ovf0, 1);
    end
    chk("ovf_sticky", ovf0, 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_cleared", ovf0, 0);

    send_one(-32768, -32768, -32768, -32768, 1'b0, 4'd7);
    lat = 1;
    while (!ov0 && lat < 20) begin tick(); lat++; end
    chk("sat_beat_valid", ov0, 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_set_wins", ovf0, 1);
    tick();
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_later_clear", ovf0, 0);

    n0 = n_out; n = 0; cyc = 0;
    while (n < 20 && cyc < 200) begin
      dout_rdy = !(cyc >= 8 && cyc < 11);
      d1i = 16'(rnd16()); d1q = 16'(rnd16()); d2i = 16'(rnd16()); d2q = 16'(rnd16());
      conj = 1'($urandom_range(0, 1)); tag = 4'(n % 16); din_v = 1'b1;
      #1 acc = rdy0;
      tick();
      if (acc) n++;
      cyc++;
    end
    din_v = 1'b0; dout_rdy = 1'b1;
    for (int c = 0; c < 50 && (n_out - n0) < 20; c++) tick();
    chk("stream_count", n_out - n0, 20);

    for (int c = 0; c < 400; c++) begin
      din_v = ($urandom_range(0, 9) < 7);
      dout_rdy = ($urandom_range(0, 3) != 0);
      d1i = 16'(rnd16()); d1q = 16'(rnd16()); d2i = 16'(rnd16()); d2q = 16'(rnd16());
      conj = 1'($urandom_range(0, 1)); tag = 4'($urandom);
      tick();
    end
    din_v = 1'b0; dout_rdy = 1'b1;
    for (int c = 0; c < 30 && sb.size() > 0; c++) tick();
    chk("drain_empty", sb.size(), 0);

    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d1i = -16'sd32768; d1q = -16'sd32768; d2i = -16'sd32768; d2q = -16'sd32768;
      conj = 1'b0; tag = 4'(k + 1); din_v = 1'b1;
      tick();
    end
    din_v = 1'b0;
    tick(); tick();
    chk("pre_rst_valid", ov0, 1);
    chk("pre_rst_ovf", ovf0, 1);
    chk("pre_rst_tag", ot0, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", ov0, 0); chk("async_ovf", ovf0, 0);
    chk("async_i", oi0, 0); chk("async_q", oq0, 0); chk("async_tag", ot0, 0);
    chk("async_sat", sat0, 0); chk("async_ready", rdy0, 1);
    chk("async_v1", ov1, 0); chk("async_v2", ov2, 0);
    chk("async_ovf1", ovf1, 0); chk("async_ovf2", ovf2, 0);
    chk("async_rdy1", rdy1, 1); chk("async_rdy2", rdy2, 1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    send_one(1, 2, 3, 4, 1'b0, 4'd9);
    for (int l = 1; l <= 8; l++) begin
      chk("post_rst_valid", ov0, longint'(l == 5));
      if (l == 5) begin
        chk("post_rst_i", oi0, 0);
        chk("post_rst_tag", ot0, 9);
        chk("post_rst_i1", oi1, -5);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
